// File: rtl/bsg_manycore_spmd_run_ctrl_pkg.sv
// Shared types for the SPMD run controller: FSM state encoding and release-time helper.
// The stat record struct depends on module widths, so it is declared inside the top.
package bsg_manycore_spmd_run_ctrl_pkg;

    typedef enum logic [2:0] {
        eIdle    = 3'd0,
        eRelease = 3'd1,
        eRun     = 3'd2,
        eDone    = 3'd3,
        eTimeout = 3'd4
    } spmd_run_state_e;

    // Release-counter value at which pod k leaves reset.
    function automatic int release_thresh(input int k, input int depth, input int stagger);
        return depth + k * stagger;
    endfunction

endpackage

// File: rtl/bsg_manycore_spmd_run_ctrl_fifo.sv
// Small circular-buffer FIFO with valid/ready input and valid/yumi output.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 8,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  mem_q [els_p];
    logic [ptr_w_lp-1:0] wptr_q, rptr_q;
    logic [cnt_w_lp-1:0] cnt_q;
    logic                enq_s, deq_s;

    function automatic logic [ptr_w_lp-1:0] next_ptr(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    assign ready_o = (cnt_q != cnt_w_lp'(els_p));
    assign v_o     = (cnt_q != '0);
    assign enq_s   = v_i & ready_o;
    assign deq_s   = yumi_i & v_o;
    assign data_o  = mem_q[rptr_q];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= enq_s ? next_ptr(wptr_q) : wptr_q;
            rptr_q <= deq_s ? next_ptr(rptr_q) : rptr_q;
            case ({enq_s, deq_s})
                2'b10:   cnt_q <= cnt_q + cnt_w_lp'(1);
                2'b01:   cnt_q <= cnt_q - cnt_w_lp'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage array write port.
    always_ff @(posedge clk_i) begin
        if (enq_s) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/bsg_manycore_spmd_run_ctrl.sv
// SPMD run controller: staggered pod reset release, global cycle counter, finish
// collection and timestamped print_stat queue. Watchdog: BSG_MANYCORE_SPMD_RUN_CTRL_WATCHDOG_EN.
module bsg_manycore_spmd_run_ctrl
    import bsg_manycore_spmd_run_ctrl_pkg::*;
#(
    parameter int num_pods_p    = 1,
    parameter int reset_depth_p = 3,
    parameter int stagger_p     = 0,
    parameter int ctr_width_p   = 32,
    parameter int data_width_p  = 32,
    parameter int stat_els_p    = 4,
    parameter int drop_width_p  = 8,
    parameter int max_cycles_p  = 1000000
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    tag_done_i,
    input  logic [num_pods_p-1:0]   finish_v_i,
    input  logic                    print_stat_v_i,
    input  logic [data_width_p-1:0] print_stat_tag_i,
    output logic [num_pods_p-1:0]   pod_reset_o,
    output logic [ctr_width_p-1:0]  global_ctr_o,
    output logic                    stat_v_o,
    output logic [data_width_p-1:0] stat_tag_o,
    output logic [ctr_width_p-1:0]  stat_cycle_o,
    input  logic                    stat_yumi_i,
    output logic [drop_width_p-1:0] stat_drop_o,
    output logic                    done_o,
    output logic                    timeout_o
);
    typedef struct packed {
        logic [data_width_p-1:0] tag;
        logic [ctr_width_p-1:0]  cycle;
    } stat_rec_s;

    localparam int rel_max_lp = release_thresh(num_pods_p - 1, reset_depth_p, stagger_p);
    localparam int rel_w_lp   = $clog2(rel_max_lp + 2);

    if (num_pods_p < 1 || reset_depth_p < 1 || stat_els_p < 2 || max_cycles_p < 1) begin : g_bad_params
        $error("bsg_manycore_spmd_run_ctrl: illegal parameter value");
    end

    spmd_run_state_e         state_q;
    logic [num_pods_p-1:0]   pod_reset_q, pod_reset_d;
    logic [num_pods_p-1:0]   fin_q, fin_d;
    logic [rel_w_lp-1:0]     rel_cnt_q, rel_cnt_d;
    logic [ctr_width_p-1:0]  ctr_q, ctr_d;
    logic [drop_width_p-1:0] drop_q, drop_d;
    logic                    done_q;
    logic                    active_s, all_rel_s, all_fin_s, push_s, fifo_ready_s;
    stat_rec_s               push_rec_s, head_rec_s;

    assign active_s  = (state_q == eRelease) || (state_q == eRun);
    assign rel_cnt_d = (state_q == eRelease) ? rel_cnt_q + rel_w_lp'(1) : '0;

    // Pods drop out of reset once the release count reaches their staggered threshold.
    always_comb begin
        pod_reset_d = pod_reset_q;
        if (state_q == eRelease) begin
            for (int k = 0; k < num_pods_p; k++) begin
                if (int'(rel_cnt_d) >= release_thresh(k, reset_depth_p, stagger_p)) begin
                    pod_reset_d[k] = 1'b0;
                end else begin
                    pod_reset_d[k] = pod_reset_q[k];
                end
            end
        end else begin
            pod_reset_d = pod_reset_q;
        end
    end

    assign all_rel_s = ~|pod_reset_d;

    // Finish pulses only count for released pods while running.
    always_comb begin
        fin_d = fin_q;
        if (state_q == eRun) begin
            fin_d = fin_q | (finish_v_i & ~pod_reset_q);
        end else begin
            fin_d = fin_q;
        end
    end

    assign all_fin_s = &fin_d;

    // Global counter runs from pod 0 release, saturates, and freezes once the run ends.
    always_comb begin
        ctr_d = ctr_q;
        if (active_s && !pod_reset_q[0] && (ctr_q != '1)) begin
            ctr_d = ctr_q + ctr_width_p'(1);
        end else begin
            ctr_d = ctr_q;
        end
    end

    assign push_s     = print_stat_v_i & active_s;
    assign push_rec_s = stat_rec_s'{tag: print_stat_tag_i, cycle: ctr_q};

    // A full queue drops the event even if the head is dequeued on the same edge.
    always_comb begin
        drop_d = drop_q;
        if (push_s && !fifo_ready_s && (drop_q != '1)) begin
            drop_d = drop_q + drop_width_p'(1);
        end else begin
            drop_d = drop_q;
        end
    end

`ifdef BSG_MANYCORE_SPMD_RUN_CTRL_WATCHDOG_EN
    logic wd_hit_s;
    logic timeout_q;
    assign wd_hit_s  = (state_q == eRun) && (ctr_q == ctr_width_p'(max_cycles_p - 1)) && !all_fin_s;
    assign timeout_o = timeout_q;

    // Sticky timeout flag, one cycle behind the FSM.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= (state_q == eTimeout);
        end
    end
`else
    assign timeout_o = 1'b0;
`endif

    // Run FSM plus its registered datapath state.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= eIdle;
            pod_reset_q <= '1;
            rel_cnt_q   <= '0;
            fin_q       <= '0;
            ctr_q       <= '0;
            drop_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            pod_reset_q <= pod_reset_d;
            rel_cnt_q   <= rel_cnt_d;
            fin_q       <= fin_d;
            ctr_q       <= ctr_d;
            drop_q      <= drop_d;
            done_q      <= (state_q == eDone);
            case (state_q)
                eIdle:    state_q <= tag_done_i ? eRelease : eIdle;
                eRelease: state_q <= all_rel_s ? eRun : eRelease;
                eRun: begin
                    if (all_fin_s) begin
                        state_q <= eDone;
                    end
`ifdef BSG_MANYCORE_SPMD_RUN_CTRL_WATCHDOG_EN
                    else if (wd_hit_s) begin
                        state_q <= eTimeout;
                    end
`endif
                    else begin
                        state_q <= eRun;
                    end
                end
                eDone:    state_q <= eDone;
                eTimeout: state_q <= eTimeout;
                default:  state_q <= eIdle;
            endcase
        end
    end

    bsg_fifo_1r1w_small #(
        .width_p($bits(stat_rec_s)),
        .els_p  (stat_els_p)
    ) stat_fifo (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .v_i    (push_s),
        .ready_o(fifo_ready_s),
        .data_i (push_rec_s),
        .v_o    (stat_v_o),
        .data_o (head_rec_s),
        .yumi_i (stat_yumi_i)
    );

    assign pod_reset_o  = pod_reset_q;
    assign global_ctr_o = ctr_q;
    assign stat_tag_o   = head_rec_s.tag;
    assign stat_cycle_o = head_rec_s.cycle;
    assign stat_drop_o  = drop_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_bsg_manycore_spmd_run_ctrl.sv
// Randomised bench for bsg_manycore_spmd_run_ctrl against a timeline-based reference model.
module tb_bsg_manycore_spmd_run_ctrl;
    localparam int N = 4, D = 3, S = 2, ELS = 4, MAX = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_i, tag_done_i, print_stat_v_i, stat_yumi_i;
    logic [N-1:0]  finish_v_i, pod_reset_o;
    logic [31:0]   print_stat_tag_i, global_ctr_o, stat_tag_o, stat_cycle_o;
    logic          stat_v_o, done_o, timeout_o;
    logic [7:0]    stat_drop_o;

    bsg_manycore_spmd_run_ctrl #(
        .num_pods_p(N), .reset_depth_p(D), .stagger_p(S), .ctr_width_p(32),
        .data_width_p(32), .stat_els_p(ELS), .drop_width_p(8), .max_cycles_p(MAX)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .tag_done_i(tag_done_i), .finish_v_i(finish_v_i),
        .print_stat_v_i(print_stat_v_i), .print_stat_tag_i(print_stat_tag_i),
        .pod_reset_o(pod_reset_o), .global_ctr_o(global_ctr_o), .stat_v_o(stat_v_o),
        .stat_tag_o(stat_tag_o), .stat_cycle_o(stat_cycle_o), .stat_yumi_i(stat_yumi_i),
        .stat_drop_o(stat_drop_o), .done_o(done_o), .timeout_o(timeout_o)
    );

    // Reference model: event times on an absolute edge index.
    typedef struct { logic [31:0] tag; logic [31:0] cyc; } rec_t;
    rec_t         mq[$];
    int           e = 0, t_tag = -1, end_e = -1;
    bit           end_to = 1'b0;
    logic [N-1:0] fin_m = '0;
    int unsigned  m_ctr = 0;
    int           m_drop = 0;
    int           n_checks = 0, n_pass = 0;

    function automatic logic [N-1:0] exp_pod_reset();
        logic [N-1:0] r;
        r = '1;
        if (t_tag >= 0)
            for (int k = 0; k < N; k++) if (e >= t_tag + D + k * S) r[k] = 1'b0;
        return r;
    endfunction
    function automatic logic exp_done();    return (end_e >= 0) && !end_to && (e > end_e); endfunction
    function automatic logic exp_timeout(); return (end_e >= 0) &&  end_to && (e > end_e); endfunction

    task automatic idle_inputs();
        finish_v_i = '0; print_stat_v_i = 1'b0; stat_yumi_i = 1'b0; print_stat_tag_i = $urandom;
    endtask

    task automatic rand_stat();
        print_stat_v_i   = 1'($urandom_range(1, 0));
        print_stat_tag_i = $urandom;
        stat_yumi_i      = (mq.size() > 0) && ($urandom_range(1, 0) == 1);
    endtask

    // One clock edge: apply the specified rules to the inputs seen at that edge.
    task automatic step();
        bit act, run, full_b;
        int unsigned ctr_b;
        @(posedge clk);
        e++;
        if (reset_i) begin
            t_tag = -1; end_e = -1; end_to = 1'b0; fin_m = '0; m_ctr = 0; m_drop = 0; mq.delete();
        end else begin
            act    = (t_tag >= 0) && (e > t_tag) && (end_e < 0 || e <= end_e);
            run    = act && (e > t_tag + D + (N - 1) * S);
            ctr_b  = m_ctr;
            full_b = (mq.size() == ELS);
            if (t_tag < 0 && tag_done_i) t_tag = e;
            if (stat_yumi_i && mq.size() > 0) void'(mq.pop_front());
            if (act && print_stat_v_i) begin
                if (full_b) begin
                    if (m_drop < 255) m_drop++;
                end else mq.push_back('{print_stat_tag_i, ctr_b});
            end
            if (run) begin
                fin_m |= finish_v_i;
                if (&fin_m) begin
                    end_e = e; end_to = 1'b0;
                end
`ifdef BSG_MANYCORE_SPMD_RUN_CTRL_WATCHDOG_EN
                else if (ctr_b == MAX - 1) begin
                    end_e = e; end_to = 1'b1;
                end
`endif
            end
            if (act && e > t_tag + D) m_ctr++;
        end
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1; tag_done_i = 1'b0; idle_inputs();
        step(); step();
        n_checks++;
        if ({pod_reset_o, global_ctr_o, stat_v_o, stat_drop_o, done_o, timeout_o} !==
            {4'hF, 32'd0, 1'b0, 8'd0, 1'b0, 1'b0})
            $display("FAIL reset_values got pod_reset=%h ctr=%0d v=%b drop=%0d done=%b to=%b want F/0/0/0/0/0",
                     pod_reset_o, global_ctr_o, stat_v_o, stat_drop_o, done_o, timeout_o);
        else n_pass++;
        reset_i = 1'b0;
        repeat (3) begin
            print_stat_v_i = 1'b1; finish_v_i = '1; step();
        end
        idle_inputs();
        n_checks++;
        if (stat_v_o !== 1'b0 || stat_drop_o !== 8'd0 || pod_reset_o !== 4'hF || done_o !== 1'b0)
            $display("FAIL idle_ignore got v=%b drop=%0d pod_reset=%h done=%b want 0/0/F/0",
                     stat_v_o, stat_drop_o, pod_reset_o, done_o);
        else n_pass++;
    endtask

    task automatic test_release();
        int base;
        repeat ($urandom_range(3, 0)) step();
        tag_done_i = 1'b1; step();
        base = t_tag;
        for (int i = 1; i <= 14; i++) begin
            finish_v_i = (e + 1 == base + 6) ? 4'b0100 : 4'b0000;
            tag_done_i = 1'($urandom_range(1, 0));
            rand_stat();
            step();
            n_checks++;
            if (pod_reset_o !== exp_pod_reset() || global_ctr_o !== m_ctr)
                $display("FAIL release_cycle e=%0d got pod_reset=%h ctr=%0d want %h/%0d",
                         e, pod_reset_o, global_ctr_o, exp_pod_reset(), m_ctr);
            else n_pass++;
            n_checks++;
            if (stat_v_o !== (mq.size() > 0) ||
                (mq.size() > 0 && (stat_tag_o !== mq[0].tag || stat_cycle_o !== mq[0].cyc)))
                $display("FAIL release_stat_head e=%0d got v=%b tag=%h cyc=%0d want v=%b",
                         e, stat_v_o, stat_tag_o, stat_cycle_o, mq.size() > 0);
            else n_pass++;
            if (e == base + 3) begin
                n_checks++;
                if (pod_reset_o !== 4'b1110 || global_ctr_o !== 32'd0)
                    $display("FAIL pod0_release got pod_reset=%h ctr=%0d want 1110/0", pod_reset_o, global_ctr_o);
                else n_pass++;
            end
            if (e == base + 8) begin
                n_checks++;
                if (pod_reset_o !== 4'b1000 || global_ctr_o !== 32'd5)
                    $display("FAIL stagger_mid got pod_reset=%h ctr=%0d want 1000/5", pod_reset_o, global_ctr_o);
                else n_pass++;
            end
        end
        idle_inputs(); tag_done_i = 1'b0;
    endtask

    task automatic test_finish();
        logic [N-1:0] seq[$];
        logic [N-1:0] pulses[4];
        logic [31:0]  frozen;
        int           last_idx;
        pulses[0] = 4'b0001; pulses[1] = 4'b0110; pulses[2] = 4'b0010; pulses[3] = 4'b1000;
        for (int p = 0; p < 4; p++) begin
            repeat ($urandom_range(8, 3)) seq.push_back('0);
            seq.push_back(pulses[p]);
        end
        last_idx = seq.size() - 1;
        repeat (6) seq.push_back('0);
        frozen = '0;
        for (int i = 0; i < seq.size(); i++) begin
            finish_v_i = seq[i]; rand_stat(); step();
            n_checks++;
            if (done_o !== exp_done() || timeout_o !== 1'b0 || global_ctr_o !== m_ctr)
                $display("FAIL finish_cycle e=%0d got done=%b to=%b ctr=%0d want %b/0/%0d",
                         e, done_o, timeout_o, global_ctr_o, exp_done(), m_ctr);
            else n_pass++;
            n_checks++;
            if (stat_v_o !== (mq.size() > 0) ||
                (mq.size() > 0 && (stat_tag_o !== mq[0].tag || stat_cycle_o !== mq[0].cyc)))
                $display("FAIL finish_stat_head e=%0d got v=%b tag=%h cyc=%0d", e, stat_v_o, stat_tag_o, stat_cycle_o);
            else n_pass++;
            if (i == last_idx) begin
                n_checks++;
                if (done_o !== 1'b0) $display("FAIL done_early got %b want 0", done_o);
                else n_pass++;
            end
            if (i == last_idx + 1) begin
                frozen = global_ctr_o;
                n_checks++;
                if (done_o !== 1'b1) $display("FAIL done_rise got %b want 1", done_o);
                else n_pass++;
            end
        end
        idle_inputs();
        n_checks++;
        if (global_ctr_o !== frozen) $display("FAIL ctr_frozen got %0d want %0d", global_ctr_o, frozen);
        else n_pass++;
        for (int k = 0; k < 8 && mq.size() > 0; k++) begin
            n_checks++;
            if (stat_v_o !== 1'b1 || stat_tag_o !== mq[0].tag || stat_cycle_o !== mq[0].cyc)
                $display("FAIL drain_after_done got v=%b tag=%h cyc=%0d want 1/%h/%0d",
                         stat_v_o, stat_tag_o, stat_cycle_o, mq[0].tag, mq[0].cyc);
            else n_pass++;
            stat_yumi_i = 1'b1; step(); stat_yumi_i = 1'b0;
        end
        n_checks++;
        if (stat_v_o !== 1'b0) $display("FAIL drained_empty got v=%b want 0", stat_v_o);
        else n_pass++;
    endtask

    task automatic test_stat_overflow();
        logic [31:0] tags[7];
        reset_i = 1'b1; step(); reset_i = 1'b0;
        tag_done_i = 1'b1; step(); tag_done_i = 1'b0;
        repeat (10) step();
        for (int i = 0; i < 6; i++) begin
            tags[i] = $urandom; print_stat_v_i = 1'b1; print_stat_tag_i = tags[i]; step();
        end
        idle_inputs();
        n_checks++;
        if (stat_drop_o !== 8'd2 || stat_v_o !== 1'b1 || stat_tag_o !== tags[0])
            $display("FAIL overflow got drop=%0d v=%b tag=%h want 2/1/%h", stat_drop_o, stat_v_o, stat_tag_o, tags[0]);
        else n_pass++;
        tags[6] = $urandom; print_stat_v_i = 1'b1; print_stat_tag_i = tags[6]; stat_yumi_i = 1'b1; step();
        idle_inputs();
        n_checks++;
        if (stat_drop_o !== 8'd3 || stat_drop_o !== 8'(m_drop))
            $display("FAIL full_with_yumi got drop=%0d want 3", stat_drop_o);
        else n_pass++;
        for (int i = 1; i < 4; i++) begin
            n_checks++;
            if (stat_v_o !== 1'b1 || stat_tag_o !== tags[i] || mq.size() == 0 || stat_cycle_o !== mq[0].cyc)
                $display("FAIL drain_order i=%0d got v=%b tag=%h cyc=%0d want tag %h", i, stat_v_o, stat_tag_o,
                         stat_cycle_o, tags[i]);
            else n_pass++;
            stat_yumi_i = 1'b1; step(); stat_yumi_i = 1'b0;
        end
        n_checks++;
        if (stat_v_o !== 1'b0) $display("FAIL overflow_empty got v=%b want 0", stat_v_o);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        repeat (2) begin
            print_stat_v_i = 1'b1; print_stat_tag_i = $urandom; step();
        end
        idle_inputs();
        n_checks++;
        if (stat_v_o !== 1'b1 || pod_reset_o !== 4'h0) $display("FAIL pre_reset got v=%b pod_reset=%h", stat_v_o, pod_reset_o);
        else n_pass++;
        reset_i = 1'b1; step(); reset_i = 1'b0;
        n_checks++;
        if ({pod_reset_o, global_ctr_o, stat_v_o, stat_drop_o, done_o, timeout_o} !==
            {4'hF, 32'd0, 1'b0, 8'd0, 1'b0, 1'b0})
            $display("FAIL mid_run_reset got pod_reset=%h ctr=%0d v=%b drop=%0d done=%b to=%b",
                     pod_reset_o, global_ctr_o, stat_v_o, stat_drop_o, done_o, timeout_o);
        else n_pass++;
    endtask

    task automatic test_watchdog();
        bit seen99;
        reset_i = 1'b1; step(); reset_i = 1'b0;
        tag_done_i = 1'b1; step(); tag_done_i = 1'b0;
        seen99 = 1'b0;
        for (int i = 0; i < 130; i++) begin
            step();
            n_checks++;
            if (timeout_o !== exp_timeout() || done_o !== 1'b0 || global_ctr_o !== m_ctr)
                $display("FAIL watchdog_cycle e=%0d got to=%b done=%b ctr=%0d want %b/0/%0d",
                         e, timeout_o, done_o, global_ctr_o, exp_timeout(), m_ctr);
            else n_pass++;
            if (!seen99 && global_ctr_o == 32'd99) begin
                seen99 = 1'b1;
                n_checks++;
                if (timeout_o !== 1'b0) $display("FAIL timeout_early got %b want 0", timeout_o);
                else n_pass++;
            end
        end
        n_checks++;
`ifdef BSG_MANYCORE_SPMD_RUN_CTRL_WATCHDOG_EN
        if (timeout_o !== 1'b1) $display("FAIL timeout_fired got %b want 1", timeout_o);
        else n_pass++;
        reset_i = 1'b1; step(); reset_i = 1'b0;
        tag_done_i = 1'b1; step(); tag_done_i = 1'b0;
        repeat (12) step();
        finish_v_i = 4'b0111; step(); finish_v_i = '0;
        for (int i = 0; i < 150 && m_ctr != MAX - 1; i++) step();
        finish_v_i = 4'b1000; step(); finish_v_i = '0;
        repeat (3) begin
            step();
            n_checks++;
            if (done_o !== 1'b1 || timeout_o !== 1'b0)
                $display("FAIL done_beats_watchdog got done=%b to=%b want 1/0", done_o, timeout_o);
            else n_pass++;
        end
`else
        if (timeout_o !== 1'b0 || global_ctr_o <= 32'd100)
            $display("FAIL no_watchdog got to=%b ctr=%0d want 0/>100", timeout_o, global_ctr_o);
        else n_pass++;
`endif
    endtask

    initial begin
        reset_i = 1'b1; tag_done_i = 1'b0; idle_inputs();
        test_reset();
        test_release();
        test_finish();
        test_stat_overflow();
        test_reset_mid_run();
        test_watchdog();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
